// File: rtl/gcn_pkg.sv
// Shared GCN weight-buffer types and default matrix geometry.
package gcn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } loader_state_t;

    localparam int DEF_WEIGHT_ROWS = 6;
    localparam int DEF_WEIGHT_COLS = 3;
    localparam int DEF_DATA_WIDTH  = 5;

endpackage

// File: rtl/weight_loader_if.sv
// Stream-in and memory-write bundle of the weight loader.
interface weight_loader_if #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 5,
    parameter int COL_WIDTH  = 2
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  col_done;
    logic [COL_WIDTH-1:0]  col_idx;
    logic                  load_done;
    logic                  busy;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data,
        input  col_done, col_idx, load_done, busy
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data,
        output col_done, col_idx, load_done, busy
    );
endinterface

// File: rtl/wrap_counter.sv
// Modulo-MAX up counter with synchronous clear and a wrap flag.
module wrap_counter #(
    parameter int MAX   = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

    assign wrap = enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/weight_loader.sv
// Column-major weight stream to weight-memory write port, with
// per-column and whole-matrix completion flags.
module weight_loader
    import gcn_pkg::*;
#(
    parameter int WEIGHT_ROWS = DEF_WEIGHT_ROWS,
    parameter int WEIGHT_COLS = DEF_WEIGHT_COLS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ROW_WIDTH   = $clog2(WEIGHT_ROWS),
    parameter int COL_WIDTH   = $clog2(WEIGHT_COLS),
    parameter int ADDR_WIDTH  = $clog2(WEIGHT_ROWS * WEIGHT_COLS)
) (
    input logic            clk,
    input logic            rst,
    weight_loader_if.slave bus
);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(WEIGHT_ROWS - 1);

    loader_state_t         state;
    logic                  go;
    logic                  accept;
    logic                  row_wrap;
    logic                  last_beat;
    logic [ROW_WIDTH-1:0]  row;
    logic [COL_WIDTH-1:0]  col;
    logic [ADDR_WIDTH-1:0] addr;

    assign bus.in_ready = (state == LOAD);
    assign bus.busy     = (state == LOAD);

    assign go     = bus.start && (state != LOAD);
    assign accept = bus.in_valid && (state == LOAD);

    wrap_counter #(
        .MAX   (WEIGHT_ROWS),
        .WIDTH (ROW_WIDTH)
    ) u_row (
        .clk    (clk),
        .rst    (rst),
        .clear  (go),
        .enable (accept),
        .count  (row),
        .wrap   (row_wrap)
    );

    wrap_counter #(
        .MAX   (WEIGHT_COLS),
        .WIDTH (COL_WIDTH)
    ) u_col (
        .clk    (clk),
        .rst    (rst),
        .clear  (go),
        .enable (row_wrap),
        .count  (col),
        .wrap   (last_beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.col_done  <= 1'b0;
            bus.col_idx   <= '0;
            bus.load_done <= 1'b0;
        end else begin
            bus.wr_en    <= accept;
            bus.col_done <= accept && (row == ROW_LAST);
            if (accept) begin
                bus.wr_addr <= addr;
                bus.wr_data <= bus.in_data;
                bus.col_idx <= col;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= LOAD;
                        addr  <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // Address returns to 0 after the last cell so it
                        // never leaves the matrix range.
                        if (last_beat) begin
                            state         <= DONE;
                            addr          <= '0;
                            bus.load_done <= 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state         <= LOAD;
                        addr          <= '0;
                        bus.load_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
